// File: rtl/debounce_scan_sched.sv
// Time-shared debounce engine: one channel compared/counted per clock, scan started by a prescaler tick.
// Optional SYNC_EN macro inserts a 2-FF input synchronizer ahead of sampling.
module debounce_scan_sched #(
  parameter int unsigned CH       = 4,
  parameter int unsigned CHW      = 2,
  parameter int unsigned N        = 3,
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CH-1:0]  keys_in,
  output logic [CH-1:0]  keys_out,
  output logic           evt_valid,
  output logic [CHW-1:0] evt_ch,
  output logic           evt_level,
  input  logic           evt_ready,
  output logic           overrun
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SCAN, STALL} state_t;

  state_t         state, state_nxt;
  logic [CHW-1:0] idx, idx_nxt;
  logic [PW-1:0]  pcnt;
  logic           tick;
  logic [CH-1:0]  keys_s;
  logic [CW-1:0]  cnt [CH];
  logic [CW-1:0]  cur_cnt;
  logic           samp, mism, hit, slot_free, do_proc, do_load;

  assign tick = (pcnt == PW'(TICK_DIV - 1));

  // Sample-tick prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

`ifdef SYNC_EN
  logic [CH-1:0] sync1, sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= keys_in;
      sync2 <= sync1;
    end
  end

  assign keys_s = sync2;
`else
  assign keys_s = keys_in;
`endif

  // Shared compare engine for the channel currently addressed by idx
  assign samp      = keys_s[idx];
  assign cur_cnt   = cnt[idx];
  assign mism      = (samp != keys_out[idx]);
  assign hit       = mism && (cur_cnt == CW'(N));
  assign slot_free = !evt_valid || evt_ready;
  assign do_load   = do_proc && hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    do_proc   = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt = SCAN;
          idx_nxt   = '0;
        end
      end
      SCAN, STALL: begin
        // A channel that needs the busy slot parks here until the slot frees
        do_proc = slot_free || !hit;
        if (state == STALL) do_proc = slot_free;
        if (do_proc) begin
          if (idx == CHW'(CH - 1)) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = SCAN;
            idx_nxt   = idx + CHW'(1);
          end
        end else begin
          state_nxt = STALL;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel counters and debounced levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      keys_out <= '0;
      for (int i = 0; i < int'(CH); i++) cnt[i] <= '0;
    end else if (do_proc) begin
      if (!mism) begin
        cnt[idx] <= '0;
      end else if (hit) begin
        cnt[idx]      <= '0;
        keys_out[idx] <= samp;
      end else begin
        cnt[idx] <= cur_cnt + CW'(1);
      end
    end
  end

  // Single-entry event slot; load wins over a same-cycle accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_level <= 1'b0;
    end else if (do_load) begin
      evt_valid <= 1'b1;
      evt_ch    <= idx;
      evt_level <= samp;
    end else if (evt_ready) begin
      evt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         overrun <= 1'b0;
    else if (tick && (state != IDLE)) overrun <= 1'b1;
  end

endmodule

// File: tb/tb_debounce_scan_sched.sv
// Bench for debounce_scan_sched: directed scenarios plus random key activity
// against a tick-level debounce model and an event scoreboard.
module tb_debounce_scan_sched;

  localparam int unsigned CH  = 4;
  localparam int unsigned CHW = 2;
  localparam int unsigned N   = 3;
  localparam int unsigned TD  = 8;
`ifdef SYNC_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [CH-1:0]  keys_in = '0;
  logic [CH-1:0]  keys_out;
  logic           evt_valid;
  logic [CHW-1:0] evt_ch;
  logic           evt_level;
  logic           evt_ready = 1'b1;
  logic           overrun;

  always #5 clk = ~clk;

  debounce_scan_sched #(.CH(CH), .CHW(CHW), .N(N), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_in   (keys_in),
    .keys_out  (keys_out),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_level (evt_level),
    .evt_ready (evt_ready),
    .overrun   (overrun)
  );

  typedef struct {
    int   ch;
    logic lvl;
  } ev_t;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-channel debounced level and consecutive-mismatch count
  int            cyc;
  logic [CH-1:0] mlev;
  int            mcnt [CH];
  logic [CH-1:0] hist [3];
  ev_t           q [$];
  int            nev = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    cyc  = 0;
    mlev = '0;
    for (int i = 0; i < int'(CH); i++) mcnt[i] = 0;
    q.delete();
  endtask

  // One clock: check registered outputs, drive keys, advance the model
  task automatic cycle(input logic [CH-1:0] k, input bit chk);
    int   c;
    int   ph;
    logic s;
    ev_t  e;
    @(negedge clk);
    c = cyc + 1;
    if (chk) begin
      if (evt_valid && evt_ready) begin
        check_eq("evt_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          nev++;
          check_eq("evt_ch", 32'(evt_ch), 32'(e.ch));
          check_eq("evt_level", 32'(evt_level), 32'(e.lvl));
        end
      end
      if (c % int'(TD) == 0) begin
        check_eq("keys_out", 32'(keys_out), 32'(mlev));
        check_eq("evt_drained", 32'(q.size()), 32'd0);
        check_eq("overrun_clear", 32'(overrun), 32'd0);
      end
    end
    keys_in = k;
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = k;
    // Channel ph is sampled (1+ph) clocks after each tick; first tick at cycle TD
    ph = (c - 1) % int'(TD);
    if (c > int'(TD) && ph < int'(CH)) begin
      s = hist[LAT][ph];
      if (s == mlev[ph]) begin
        mcnt[ph] = 0;
      end else if (mcnt[ph] < int'(N)) begin
        mcnt[ph]++;
      end else begin
        mlev[ph] = s;
        mcnt[ph] = 0;
        q.push_back('{ch: ph, lvl: s});
      end
    end
    @(posedge clk);
    cyc = c;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_keys_out"}, 32'(keys_out), 32'd0);
    check_eq({tag, "_evt_valid"}, 32'(evt_valid), 32'd0);
    check_eq({tag, "_evt_ch"}, 32'(evt_ch), 32'd0);
    check_eq({tag, "_evt_level"}, 32'(evt_level), 32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero(tag);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
  endtask

  initial begin
    int            n0;
    logic [CH-1:0] rk;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;

    // Steady step on ch2: flips on the 4th tick scan, exactly one event
    n0 = nev;
    repeat (32) cycle(4'b0100, 1'b1);
    #1 check_eq("t2_before_4th_tick", 32'(keys_out), 32'h0);
    repeat (8) cycle(4'b0100, 1'b1);
    #1 check_eq("t2_after_4th_tick", 32'(keys_out), 32'h4);
    check_eq("t2_event_count", 32'(nev - n0), 32'd1);

    // ch1 pulse lasting 3 ticks: no flip, count falls back to 0
    n0 = nev;
    repeat (24) cycle(4'b0110, 1'b1);
    repeat (16) cycle(4'b0100, 1'b1);
    #1 check_eq("t3_keys_out", 32'(keys_out), 32'h4);
    check_eq("t3_no_event", 32'(nev - n0), 32'd0);

    // Reset while ch1 is being processed with count 2
    repeat (17) cycle(4'b0110, 1'b1);
    do_reset("t1_midscan");
    repeat (32) cycle(4'b0110, 1'b1);
    #1 check_eq("t1_after_3_ticks", 32'(keys_out), 32'h0);
    repeat (8) cycle(4'b0110, 1'b1);
    #1 check_eq("t1_after_4_ticks", 32'(keys_out), 32'h6);

    // ch2 toggles every clock; only tick-aligned samples matter
    n0 = nev;
    for (int i = 0; i < 64; i++) cycle((i % 2 == 1) ? 4'b0110 : 4'b0010, 1'b1);
    check_eq("t5_event_count", 32'(nev - n0), 32'd1);
    check_eq("t5_keys_out", 32'(keys_out), 32'h2);

    // Random key activity with occasional bounces
    rk = 4'b0010;
    repeat (1600) begin
      if ($urandom_range(0, 5) == 0) rk[$urandom_range(0, 3)] ^= 1'b1;
      cycle(rk, 1'b1);
    end
    repeat (16) cycle(rk, 1'b1);
    check_eq("rand_queue_empty", 32'(q.size()), 32'd0);

    // Blocked consumer: ch0 event held, ch3 stalls past the next tick
    keys_in   = 4'b1001;
    for (int i = 0; i < 3; i++) hist[i] = 4'b1001;
    evt_ready = 1'b0;
    do_reset("t4_reset");
    repeat (43) cycle(4'b1001, 1'b0);
    #1;
    check_eq("t4_held_valid", 32'(evt_valid), 32'd1);
    check_eq("t4_held_ch", 32'(evt_ch), 32'd0);
    check_eq("t4_held_level", 32'(evt_level), 32'd1);
    check_eq("t4_keys_stalled", 32'(keys_out), 32'h1);
    check_eq("t4_overrun", 32'(overrun), 32'd1);
    @(negedge clk);
    evt_ready = 1'b1;
    check_eq("t4_accept_ch", 32'(evt_ch), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t4_reload_valid", 32'(evt_valid), 32'd1);
    check_eq("t4_reload_ch", 32'(evt_ch), 32'd3);
    check_eq("t4_reload_level", 32'(evt_level), 32'd1);
    check_eq("t4_keys_released", 32'(keys_out), 32'h9);
    @(posedge clk);
    #1;
    check_eq("t4_drained", 32'(evt_valid), 32'd0);
    check_eq("t4_overrun_sticky", 32'(overrun), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
